// File: rtl/conv_engine_seq.sv
// Sequential 2-D valid-mode convolution engine: one MAC per clock, stride 1 or 2.
// Optional CONV_SATURATE_EN clamps each result to all-ones instead of truncating.
module conv_engine_seq #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned MAX_IN = 5,
   parameter int unsigned MAX_K  = 3,
   parameter int unsigned DIM_W  = 3,
   parameter int unsigned KDIM_W = 2,
   parameter int unsigned CNT_W  = 10
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_start,
   input  logic                              i_stride,
   input  logic [DIM_W-1:0]                  i_in_m,
   input  logic [DIM_W-1:0]                  i_in_n,
   input  logic [KDIM_W-1:0]                 i_k_m,
   input  logic [KDIM_W-1:0]                 i_k_n,
   input  logic [MAX_IN*MAX_IN*DATA_W-1:0]   i_matrix_in,
   input  logic [MAX_K*MAX_K*DATA_W-1:0]     i_kernel_in,
   output logic                              o_busy,
   output logic                              o_done,
   output logic                              o_valid,
   output logic                              o_err,
   output logic [DIM_W-1:0]                  o_out_m,
   output logic [DIM_W-1:0]                  o_out_n,
   output logic [MAX_IN*MAX_IN*DATA_W-1:0]   o_matrix_out,
   output logic [CNT_W-1:0]                  o_cycle_count
);

   localparam int unsigned ACC_W = 2 * DATA_W + 4;

   typedef enum logic [2:0] {StIdle, StCheck, StMac, StWrite, StFin} state_e;

   state_e                            r_state;
   logic                              r_stride;
   logic [DIM_W-1:0]                  r_in_m, r_in_n, r_out_m, r_out_n, r_i, r_j;
   logic [KDIM_W-1:0]                 r_k_m, r_k_n, r_kr, r_kc;
   logic [MAX_IN*MAX_IN*DATA_W-1:0]   r_mat, r_out;
   logic [MAX_K*MAX_K*DATA_W-1:0]     r_ker;
   logic [ACC_W-1:0]                  r_acc;
   logic [CNT_W-1:0]                  r_cnt;
   logic                              r_busy, r_done, r_valid, r_err;

   int unsigned                       w_s, w_in_idx, w_k_idx, w_out_idx;
   logic [ACC_W-1:0]                  w_prod;
   logic [DATA_W-1:0]                 w_res;
   logic                              w_dim_err, w_last_kc, w_last_k, w_last_j, w_last_i;
   logic [DIM_W-1:0]                  w_out_m, w_out_n;

   always_comb begin
      w_s       = r_stride ? 32'd2 : 32'd1;
      w_in_idx  = (32'(r_i) * w_s + 32'(r_kr)) * MAX_IN + 32'(r_j) * w_s + 32'(r_kc);
      w_k_idx   = 32'(r_kr) * MAX_K + 32'(r_kc);
      w_out_idx = 32'(r_i) * MAX_IN + 32'(r_j);
      w_prod    = ACC_W'(r_mat[w_in_idx*DATA_W +: DATA_W])
                * ACC_W'(r_ker[w_k_idx*DATA_W +: DATA_W]);
   end

   assign w_dim_err = (r_in_m == '0) || (32'(r_in_m) > MAX_IN)
                   || (r_in_n == '0) || (32'(r_in_n) > MAX_IN)
                   || (r_k_m == '0) || (32'(r_k_m) > MAX_K)
                   || (r_k_n == '0) || (32'(r_k_n) > MAX_K)
                   || (32'(r_k_m) > 32'(r_in_m)) || (32'(r_k_n) > 32'(r_in_n));

   // Divide by the stride is a shift since the stride is 1 or 2.
   assign w_out_m = DIM_W'(((32'(r_in_m) - 32'(r_k_m)) >> r_stride) + 32'd1);
   assign w_out_n = DIM_W'(((32'(r_in_n) - 32'(r_k_n)) >> r_stride) + 32'd1);

   assign w_last_kc = (32'(r_kc) + 32'd1 == 32'(r_k_n));
   assign w_last_k  = w_last_kc && (32'(r_kr) + 32'd1 == 32'(r_k_m));
   assign w_last_j  = (32'(r_j) + 32'd1 == 32'(r_out_n));
   assign w_last_i  = (32'(r_i) + 32'd1 == 32'(r_out_m));

`ifdef CONV_SATURATE_EN
   assign w_res = (r_acc > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : r_acc[DATA_W-1:0];
`else
   assign w_res = r_acc[DATA_W-1:0];
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= StIdle;
         r_stride <= 1'b0;
         r_in_m   <= '0;
         r_in_n   <= '0;
         r_k_m    <= '0;
         r_k_n    <= '0;
         r_mat    <= '0;
         r_ker    <= '0;
         r_out    <= '0;
         r_out_m  <= '0;
         r_out_n  <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_kr     <= '0;
         r_kc     <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_stride <= i_stride;
                  r_in_m   <= i_in_m;
                  r_in_n   <= i_in_n;
                  r_k_m    <= i_k_m;
                  r_k_n    <= i_k_n;
                  r_mat    <= i_matrix_in;
                  r_ker    <= i_kernel_in;
                  r_out    <= '0;
                  r_valid  <= 1'b0;
                  r_err    <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= StCheck;
               end
            end
            StCheck: begin
               if (w_dim_err) begin
                  r_err   <= 1'b1;
                  r_out_m <= '0;
                  r_out_n <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_valid <= 1'b0;
                  r_state <= StFin;
               end else begin
                  r_out_m <= w_out_m;
                  r_out_n <= w_out_n;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_kr    <= '0;
                  r_kc    <= '0;
                  r_acc   <= '0;
                  r_state <= StMac;
               end
            end
            StMac: begin
               r_acc <= r_acc + w_prod;
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               if (w_last_kc) begin
                  r_kc <= '0;
                  r_kr <= r_kr + 1'b1;
               end else begin
                  r_kc <= r_kc + 1'b1;
               end
               if (w_last_k) begin
                  r_kr    <= '0;
                  r_state <= StWrite;
               end
            end
            StWrite: begin
               r_out[w_out_idx*DATA_W +: DATA_W] <= w_res;
               r_acc   <= '0;
               r_state <= StMac;
               if (w_last_j) begin
                  r_j <= '0;
                  if (w_last_i) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_valid <= 1'b1;
                     r_state <= StFin;
                  end else begin
                     r_i <= r_i + 1'b1;
                  end
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            StFin: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_valid       = r_valid;
   assign o_err         = r_err;
   assign o_out_m       = r_out_m;
   assign o_out_n       = r_out_n;
   assign o_matrix_out  = r_out;
   assign o_cycle_count = r_cnt;

endmodule

// File: tb/tb_conv_engine_seq.sv
// Bench for conv_engine_seq: directed vector table, random ops against a reference model,
// plus hand sequences for start re-pulse and mid-operation reset.
module tb_conv_engine_seq;

   localparam int MAT_W = 200;
   localparam int KER_W = 72;

   typedef struct {
      logic             stride;
      logic [2:0]       in_m, in_n;
      logic [1:0]       k_m, k_n;
      logic [MAT_W-1:0] mat;
      logic [KER_W-1:0] ker;
      logic             exp_err, exp_valid;
      logic [2:0]       exp_om, exp_on;
      logic [MAT_W-1:0] exp_mat;
      logic [9:0]       exp_cnt;
      int               exp_lat;
   } vec_t;

   logic             clk = 1'b0, reset = 1'b1, start = 1'b0, stride = 1'b0;
   logic [2:0]       in_m = '0, in_n = '0;
   logic [1:0]       k_m = '0, k_n = '0;
   logic [MAT_W-1:0] matrix_in = '0;
   logic [KER_W-1:0] kernel_in = '0;
   logic             busy, done, valid, err;
   logic [2:0]       out_m, out_n;
   logic [MAT_W-1:0] matrix_out;
   logic [9:0]       cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   conv_engine_seq dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_stride(stride),
      .i_in_m(in_m), .i_in_n(in_n), .i_k_m(k_m), .i_k_n(k_n),
      .i_matrix_in(matrix_in), .i_kernel_in(kernel_in),
      .o_busy(busy), .o_done(done), .o_valid(valid), .o_err(err),
      .o_out_m(out_m), .o_out_n(out_n), .o_matrix_out(matrix_out),
      .o_cycle_count(cycle_count)
   );

   task automatic chk(input string name, input logic [MAT_W-1:0] got,
                      input logic [MAT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic vec_t blank();
      vec_t v;
      v.stride = 1'b0; v.in_m = '0; v.in_n = '0; v.k_m = '0; v.k_n = '0;
      v.mat = '0; v.ker = '0; v.exp_err = 1'b0; v.exp_valid = 1'b0;
      v.exp_om = '0; v.exp_on = '0; v.exp_mat = '0; v.exp_cnt = '0; v.exp_lat = 0;
      return v;
   endfunction

   // Reference: direct evaluation of the convolution sum over each output position.
   function automatic vec_t model(input vec_t v);
      vec_t e;
      int s, om, on, p, kk;
      longint sum, val;
      e = v;
      s = v.stride ? 2 : 1;
      e.exp_err = (v.in_m == 0) || (v.in_m > 5) || (v.in_n == 0) || (v.in_n > 5)
               || (v.k_m == 0) || (v.k_n == 0) || (v.k_m > v.in_m) || (v.k_n > v.in_n);
      e.exp_valid = !e.exp_err;
      e.exp_mat = '0;
      if (e.exp_err) begin
         e.exp_om = '0; e.exp_on = '0; e.exp_cnt = '0; e.exp_lat = 1;
      end else begin
         om = (int'(v.in_m) - int'(v.k_m)) / s + 1;
         on = (int'(v.in_n) - int'(v.k_n)) / s + 1;
         for (int i = 0; i < om; i++) begin
            for (int j = 0; j < on; j++) begin
               sum = 0;
               for (int kr = 0; kr < int'(v.k_m); kr++)
                  for (int kc = 0; kc < int'(v.k_n); kc++)
                     sum += longint'(v.mat[((i*s+kr)*5 + j*s+kc)*8 +: 8])
                          * longint'(v.ker[(kr*3+kc)*8 +: 8]);
`ifdef CONV_SATURATE_EN
               val = (sum > 255) ? 255 : sum;
`else
               val = sum % 256;
`endif
               e.exp_mat[(i*5+j)*8 +: 8] = 8'(val);
            end
         end
         p  = om * on;
         kk = int'(v.k_m) * int'(v.k_n);
         e.exp_om  = 3'(om);
         e.exp_on  = 3'(on);
         e.exp_cnt = (p * kk > 1023) ? 10'd1023 : 10'(p * kk);
         e.exp_lat = 1 + p * (kk + 1);
      end
      return e;
   endfunction

   // Start an op; optionally re-pulse start at edge t0+repulse. Returns edges until done.
   task automatic run_op(input string tag, input vec_t v, input int repulse, output int lat);
      @(negedge clk);
      stride = v.stride; in_m = v.in_m; in_n = v.in_n; k_m = v.k_m; k_n = v.k_n;
      matrix_in = v.mat; kernel_in = v.ker; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "/busy_at_start"}, busy, 1'b1);
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         if (n == repulse) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input vec_t v, input int lat);
      chk({tag, "/latency"}, lat, v.exp_lat);
      chk({tag, "/valid"}, valid, v.exp_valid);
      chk({tag, "/err"}, err, v.exp_err);
      chk({tag, "/out_m"}, out_m, v.exp_om);
      chk({tag, "/out_n"}, out_n, v.exp_on);
      chk({tag, "/matrix_out"}, matrix_out, v.exp_mat);
      chk({tag, "/cycle_count"}, cycle_count, v.exp_cnt);
      chk({tag, "/busy_at_done"}, busy, 1'b0);
      @(posedge clk); #1;
      chk({tag, "/done_one_cycle"}, done, 1'b0);
      chk({tag, "/valid_hold"}, valid, v.exp_valid);
   endtask

   initial begin
      vec_t dir[5];
      vec_t v;
      int   lat;
      int   exp9[9];

      // Directed table
      exp9 = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
      v = blank();
      v.in_m = 3'd4; v.in_n = 3'd4; v.k_m = 2'd2; v.k_n = 2'd2;
      for (int i = 0; i < 16; i++) v.mat[((i/4)*5 + i%4)*8 +: 8] = 8'(i + 1);
      for (int i = 0; i < 4; i++) v.ker[((i/2)*3 + i%2)*8 +: 8] = 8'd1;
      v.exp_valid = 1'b1; v.exp_om = 3'd3; v.exp_on = 3'd3; v.exp_cnt = 10'd36; v.exp_lat = 46;
      for (int i = 0; i < 9; i++) v.exp_mat[((i/3)*5 + i%3)*8 +: 8] = 8'(exp9[i]);
      dir[0] = v;

      v = blank();
      v.stride = 1'b1; v.in_m = 3'd5; v.in_n = 3'd5; v.k_m = 2'd3; v.k_n = 2'd3;
      for (int i = 0; i < 25; i++) v.mat[i*8 +: 8] = 8'd1;
      for (int i = 0; i < 9; i++) v.ker[i*8 +: 8] = 8'd1;
      v.exp_valid = 1'b1; v.exp_om = 3'd2; v.exp_on = 3'd2; v.exp_cnt = 10'd36; v.exp_lat = 41;
      for (int i = 0; i < 4; i++) v.exp_mat[((i/2)*5 + i%2)*8 +: 8] = 8'd9;
      dir[1] = v;

      v = blank();
      v.in_m = 3'd2; v.in_n = 3'd2; v.k_m = 2'd3; v.k_n = 2'd1;
      v.mat = {MAT_W{1'b1}}; v.ker = {KER_W{1'b1}};
      v.exp_err = 1'b1; v.exp_lat = 1;
      dir[2] = v;

      v = blank();
      v.in_m = 3'd3; v.in_n = 3'd3; v.k_m = 2'd0; v.k_n = 2'd2;
      v.mat = {MAT_W{1'b1}}; v.ker = {KER_W{1'b1}};
      v.exp_err = 1'b1; v.exp_lat = 1;
      dir[3] = v;

      v = blank();
      v.in_m = 3'd2; v.in_n = 3'd2; v.k_m = 2'd2; v.k_n = 2'd2;
      for (int i = 0; i < 4; i++) v.mat[((i/2)*5 + i%2)*8 +: 8] = 8'd200;
      for (int i = 0; i < 4; i++) v.ker[((i/2)*3 + i%2)*8 +: 8] = 8'd1;
      v.exp_valid = 1'b1; v.exp_om = 3'd1; v.exp_on = 3'd1; v.exp_cnt = 10'd4; v.exp_lat = 6;
`ifdef CONV_SATURATE_EN
      v.exp_mat[7:0] = 8'd255;
`else
      v.exp_mat[7:0] = 8'd32;
`endif
      dir[4] = v;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset/busy", busy, 1'b0);
      chk("reset/done", done, 1'b0);
      chk("reset/valid", valid, 1'b0);
      chk("reset/err", err, 1'b0);
      chk("reset/out_m", out_m, 3'd0);
      chk("reset/out_n", out_n, 3'd0);
      chk("reset/matrix_out", matrix_out, '0);
      chk("reset/cycle_count", cycle_count, 10'd0);
      reset = 1'b0;

      for (int t = 0; t < 5; t++) begin
         run_op($sformatf("dir%0d", t), dir[t], 0, lat);
         check_result($sformatf("dir%0d", t), dir[t], lat);
      end

      // Random operations against the model
      for (int t = 0; t < 25; t++) begin
         v = blank();
         v.stride = 1'($urandom);
         if (t % 4 == 0) begin
            v.in_m = 3'($urandom_range(0, 7)); v.in_n = 3'($urandom_range(0, 7));
            v.k_m  = 2'($urandom_range(0, 3)); v.k_n  = 2'($urandom_range(0, 3));
         end else begin
            v.in_m = 3'($urandom_range(3, 5)); v.in_n = 3'($urandom_range(3, 5));
            v.k_m  = 2'($urandom_range(1, 3)); v.k_n  = 2'($urandom_range(1, 3));
         end
         for (int i = 0; i < 25; i++) v.mat[i*8 +: 8] = 8'($urandom);
         for (int i = 0; i < 9; i++) v.ker[i*8 +: 8] = 8'($urandom);
         v = model(v);
         run_op($sformatf("rnd%0d", t), v, 0, lat);
         check_result($sformatf("rnd%0d", t), v, lat);
      end

      // start re-pulsed mid-operation must be ignored
      run_op("repulse", dir[0], 5, lat);
      check_result("repulse", dir[0], lat);

      // Reset mid-MAC aborts the operation
      @(negedge clk);
      stride = dir[0].stride; in_m = dir[0].in_m; in_n = dir[0].in_n;
      k_m = dir[0].k_m; k_n = dir[0].k_n;
      matrix_in = dir[0].mat; kernel_in = dir[0].ker; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      chk("midrst/busy_before", busy, 1'b1);
      chk("midrst/count_before", cycle_count, 10'd7);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst/busy", busy, 1'b0);
      chk("midrst/valid", valid, 1'b0);
      chk("midrst/done", done, 1'b0);
      chk("midrst/out_m", out_m, 3'd0);
      chk("midrst/matrix_out", matrix_out, '0);
      chk("midrst/cycle_count", cycle_count, 10'd0);
      run_op("after_rst", dir[0], 0, lat);
      check_result("after_rst", dir[0], lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_engine_seq.md
Name: conv_engine_seq

Overview:
- Sequential, parametrised 2-D valid-mode convolution engine; successor to the combinational ConvolutionUnit in the matrix-compute datapath.
- Computes one multiply-accumulate per clock under a start/busy/done handshake.
- Adds stride 1 or 2, an error flag, and an exact MAC cycle count.
- Operand and result matrices use the packed flat-bus layout of the existing matrix units.

Parameters:
- DATA_W, 8: element width (unsigned).
- MAX_IN, 5: maximum input rows/cols; also the output bus row pitch.
- MAX_K, 3: maximum kernel rows/cols; also the kernel bus row pitch.
- DIM_W, 3: width of the input/output dimension fields.
- KDIM_W, 2: width of the kernel dimension fields.
- CNT_W, 10: width of cycle_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- stride  in  1  0 = stride 1, 1 = stride 2.
- in_m, in_n  in  DIM_W  input rows, cols.
- k_m, k_n  in  KDIM_W  kernel rows, cols.
- matrix_in  in  MAX_IN*MAX_IN*DATA_W  element (r,c) at bits [(r*MAX_IN+c)*DATA_W +: DATA_W].
- kernel_in  in  MAX_K*MAX_K*DATA_W  element (r,c) at bits [(r*MAX_K+c)*DATA_W +: DATA_W].
- busy  out  1  high from start acceptance until FIN.
- done  out  1  one-cycle completion pulse.
- valid  out  1  result valid (level).
- err  out  1  dimension error (level).
- out_m, out_n  out  DIM_W  result dimensions.
- matrix_out  out  MAX_IN*MAX_IN*DATA_W  result, same layout as matrix_in.
- cycle_count  out  CNT_W  number of MAC cycles performed.

Behaviour:
- Reset values: busy = done = valid = err = 0; out_m = out_n = 0; matrix_out = 0; cycle_count = 0; state = IDLE.
- Reset applied in any state, including mid-MAC, aborts the operation and restores reset values on the next edge.
- FSM states: IDLE, CHECK, MAC, WRITE, FIN.
- IDLE -> CHECK on the edge where start=1:
  - Latch all operands.
  - Clear matrix_out, valid, err and cycle_count.
  - Set busy.
- start is ignored in every state other than IDLE.
- CHECK sets err and goes to FIN when any of the following holds:
  - in_m or in_n is 0 or > MAX_IN;
  - k_m or k_n is 0 or > MAX_K;
  - k_m > in_m or k_n > in_n.
- When err is set, out_m = out_n = 0 and cycle_count = 0.
- Otherwise CHECK goes to MAC, with out_m = (in_m-k_m)/S + 1 and out_n = (in_n-k_n)/S + 1, where S = stride ? 2 : 1.
- MAC: exactly one product per cycle, in kernel row-major order.
  - Accumulate = sum of in[i*S+kr][j*S+kc] * k[kr][kc].
  - Accumulator width is 2*DATA_W+4, unsigned.
  - cycle_count increments each MAC cycle and saturates at all-ones.
- WRITE: one cycle per output element.
  - Store the result at output (i,j), then clear the accumulator.
  - Outputs are produced in row-major order; go to FIN after the last one, otherwise back to MAC.
- FIN: done = 1 for exactly one cycle; busy drops; valid = !err; then -> IDLE.
- Latency: with start sampled at edge t0, done rises at edge t0+N.
  - Success: N = 1 + P*(K+1), where P = out_m*out_n and K = k_m*k_n.
  - Error: N = 1.
- valid, err, out_m, out_n, matrix_out and cycle_count hold until the next accepted start or reset.
- Output elements outside out_m x out_n read 0.

Optional Feature:
- Macro: CONV_SATURATE_EN.
- Defined: a result exceeding 2^DATA_W-1 is written as all-ones.
- Undefined: the low DATA_W bits are written (truncation).

Test Plan:
- 4x4 input 1..16 row-major, 2x2 all-ones kernel, stride 0, start pulse -> done at t0+46; valid=1, out 3x3 = 14 18 22 / 30 34 38 / 46 50 54; cycle_count=36; unused elements 0.
- 5x5 all-ones input, 3x3 all-ones kernel, stride 1 -> out 2x2 all 9; cycle_count=36; done at t0+41.
- in 2x2, kernel 3x1 -> done at t0+1; err=1, valid=0, out_m=out_n=0, cycle_count=0; kernel dims 0 also flag err.
- 2x2 input all 200, 2x2 all-ones kernel -> single result 32 without CONV_SATURATE_EN, 255 with it.
- start re-pulsed at t0+5 during the first case -> ignored, identical result and timing; reset at t0+10 -> next cycle busy=0, valid=0, matrix_out=0, state IDLE; a fresh start then completes normally.
